weight_block_streamer: RTL

Parametrised weight-stream buffer for the WEIGHT interface. It captures one weight block of WEIGHT_BDIM elements from an AXI-Stream input carrying IN_ELEMS elements per beat, then replays that block NUM_REPS times at WEIGHT_SDIM elements per beat. Two ping-pong banks let the next block load while the current block replays. It sits between the weight DMA/stream source and the compute array's weight port.

---
 rtl/weight_block_streamer_pkg.sv | 26 ++
 rtl/weight_block_streamer_if.sv | 16 +
 rtl/weight_block_streamer_bank.sv | 43 ++++
 rtl/weight_block_streamer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/weight_block_streamer_pkg.sv
// Shared constants and helpers for the weight block streamer.
// - cnt_width(): counter width for a modulo-n counter, never below 1 bit.
// - beats(): beats needed to move one block at a given lane count.
// - params_ok(): legality of a parameter set; the top refuses to elaborate otherwise.
// - elem_t: one weight element at the default element width.
package weight_stream_pkg;

    localparam int DEF_ELEM_WIDTH = 8;

    typedef logic [DEF_ELEM_WIDTH-1:0] elem_t;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int beats(input int bdim, input int per_beat);
        return bdim / per_beat;
    endfunction

    function automatic bit params_ok(input int ew, input int ie, input int bd,
                                     input int sd, input int nr);
        return (ew > 0) && (ie > 0) && (sd > 0) && (bd > 0) &&
               (bd % ie == 0) && (bd % sd == 0) && (nr >= 1);
    endfunction

endpackage

// File: rtl/weight_block_streamer_if.sv
// AXI-Stream style channel used on both sides of the weight block streamer.
// Handshake: a beat transfers on a rising clock edge where tvalid && tready.
// Once tvalid is raised by the master, tdata/tlast hold until that transfer.
// - master: drives tdata, tvalid, tlast; samples tready.
// - slave:  samples tdata, tvalid, tlast; drives tready.
interface weight_block_streamer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/weight_block_streamer_bank.sv
// weight_bank: storage for one weight block of WEIGHT_BDIM elements.
// - clk     : write clock
// - wr_en   : write IN_ELEMS lanes at element wr_idx*IN_ELEMS
// - wr_idx  : input beat position within the block
// - wr_data : IN_ELEMS lanes, lane i at [i*ELEM_WIDTH +: ELEM_WIDTH]
// - rd_idx  : output beat position within the block
// - rd_data : WEIGHT_SDIM lanes starting at element rd_idx*WEIGHT_SDIM (combinational)
module weight_bank
    import weight_stream_pkg::*;
#(
    parameter int ELEM_WIDTH  = 8,
    parameter int IN_ELEMS    = 4,
    parameter int WEIGHT_SDIM = 8,
    parameter int WEIGHT_BDIM = 64
) (
    input  logic                                                clk,
    input  logic                                                wr_en,
    input  logic [cnt_width(WEIGHT_BDIM/IN_ELEMS)-1:0]          wr_idx,
    input  logic [IN_ELEMS*ELEM_WIDTH-1:0]                      wr_data,
    input  logic [cnt_width(WEIGHT_BDIM/WEIGHT_SDIM)-1:0]       rd_idx,
    output logic [WEIGHT_SDIM*ELEM_WIDTH-1:0]                   rd_data
);
    localparam int IDX_W = cnt_width(WEIGHT_BDIM);

    // Contents need no reset: a bank is only read after a full block lands in it.
    logic [ELEM_WIDTH-1:0] mem [WEIGHT_BDIM];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < IN_ELEMS; i++) begin
                mem[IDX_W'(wr_idx) * IDX_W'(IN_ELEMS) + IDX_W'(i)] <= wr_data[i*ELEM_WIDTH +: ELEM_WIDTH];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < WEIGHT_SDIM; i++) begin
            rd_data[i*ELEM_WIDTH +: ELEM_WIDTH] = mem[IDX_W'(rd_idx) * IDX_W'(WEIGHT_SDIM) + IDX_W'(i)];
        end
    end

endmodule

// File: rtl/weight_block_streamer.sv
// weight_block_streamer: captures weight blocks from an input stream into two
// ping-pong banks and replays each block NUM_REPS times on the output stream.
// - ap_clk, ap_rst   : clock, asynchronous active-high reset
// - weights_V        : input stream, IN_ELEMS elements per beat (slave side)
// - m_axis_output0   : output stream, WEIGHT_SDIM elements per beat, tlast on
//                      the last beat of every replay (master side)
// - bank_full        : per-bank full flags, exposed for status/debug
module weight_block_streamer
    import weight_stream_pkg::*;
#(
    parameter int ELEM_WIDTH  = 8,
    parameter int IN_ELEMS    = 4,
    parameter int WEIGHT_BDIM = 64,
    parameter int WEIGHT_SDIM = 8,
    parameter int NUM_REPS    = 4
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    weight_block_streamer_if.slave  weights_V,
    weight_block_streamer_if.master m_axis_output0,
    output logic [1:0]              bank_full
);
    if (!params_ok(ELEM_WIDTH, IN_ELEMS, WEIGHT_BDIM, WEIGHT_SDIM, NUM_REPS)) begin : g_bad_params
        $fatal(1, "weight_block_streamer: illegal parameter set");
    end

    localparam int BEATS_IN  = beats(WEIGHT_BDIM, IN_ELEMS);
    localparam int BEATS_OUT = beats(WEIGHT_BDIM, WEIGHT_SDIM);
    localparam int WR_W      = cnt_width(BEATS_IN);
    localparam int RB_W      = cnt_width(BEATS_OUT);
    localparam int REP_W     = cnt_width(NUM_REPS);
    localparam int OW        = WEIGHT_SDIM * ELEM_WIDTH;

    logic             wr_sel;
    logic             rd_sel;
    logic [WR_W-1:0]  wr_cnt;
    logic [RB_W-1:0]  rd_beat;
    logic [REP_W-1:0] rep;
    logic [OW-1:0]    out_data;
    logic             out_valid;
    logic             out_last;

    logic             wr_fire;
    logic             wr_done;
    logic             last_beat;
    logic             last_rep;
    logic             rd_load;
    logic             rd_final;
    logic [1:0]       bank_full_nxt;
    logic [OW-1:0]    bank_rd [2];

    // Ready depends only on registers and reset, never on tvalid.
    assign weights_V.tready = !ap_rst && !bank_full[wr_sel];

    assign wr_fire   = weights_V.tvalid && weights_V.tready;
    assign wr_done   = wr_fire && (wr_cnt == WR_W'(BEATS_IN - 1));
    assign last_beat = (rd_beat == RB_W'(BEATS_OUT - 1));
    assign last_rep  = (rep == REP_W'(NUM_REPS - 1));
    assign rd_load   = (!out_valid || m_axis_output0.tready) && bank_full[rd_sel];
    assign rd_final  = rd_load && last_beat && last_rep;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        weight_bank #(
            .ELEM_WIDTH (ELEM_WIDTH),
            .IN_ELEMS   (IN_ELEMS),
            .WEIGHT_SDIM(WEIGHT_SDIM),
            .WEIGHT_BDIM(WEIGHT_BDIM)
        ) u_bank (
            .clk    (ap_clk),
            .wr_en  (wr_fire && (wr_sel == 1'(b))),
            .wr_idx (wr_cnt),
            .wr_data(weights_V.tdata),
            .rd_idx (rd_beat),
            .rd_data(bank_rd[b])
        );
    end

    // Filling and draining always touch different banks (a bank being filled
    // is empty, a bank being drained is full), so both updates can apply.
    always_comb begin
        bank_full_nxt = bank_full;
        if (wr_done) bank_full_nxt[wr_sel] = 1'b1;
        if (rd_final) bank_full_nxt[rd_sel] = 1'b0;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= bank_full_nxt;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_sel <= 1'b0;
            wr_cnt <= '0;
        end else if (wr_fire) begin
            if (wr_done) begin
                wr_cnt <= '0;
                wr_sel <= ~wr_sel;
            end else begin
                wr_cnt <= wr_cnt + WR_W'(1);
            end
        end
    end

    // Single output register stage; it reloads in the same cycle it is
    // consumed, which keeps one beat per cycle across block boundaries.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rd_sel    <= 1'b0;
            rd_beat   <= '0;
            rep       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (rd_load) begin
            out_valid <= 1'b1;
            out_data  <= bank_rd[rd_sel];
            out_last  <= last_beat;
            if (last_beat) begin
                rd_beat <= '0;
                if (last_rep) begin
                    rep    <= '0;
                    rd_sel <= ~rd_sel;
                end else begin
                    rep <= rep + REP_W'(1);
                end
            end else begin
                rd_beat <= rd_beat + RB_W'(1);
            end
        end else if (m_axis_output0.tready) begin
            out_valid <= 1'b0;
        end
    end

    assign m_axis_output0.tdata  = out_data;
    assign m_axis_output0.tvalid = out_valid;
    assign m_axis_output0.tlast  = out_last;

endmodule
